modmul_arbiter: RTL and testbench
=================================

# modmul_arbiter

Two-requester arbiter and sequencer for the shared modular-multiply resource: the `emul_sql` multiplier followed by the `modn` reducer. It lets two independent exponentiation controllers compute `(a*b) mod n` on one multiplier/reducer pair without duplicating hardware. It grants one requester at a time, round-robin, and sequences clear, multiply, clear and reduce on the two sub-units. It returns the 8-bit result with a one-cycle done pulse and flags zero moduli and sub-unit timeouts.

## Interface
Parameters:
- DATA_WIDTH, 8, operand/result width
- DATA_DOUBLE_WIDTH, 16, product width; must equal 2*DATA_WIDTH
- TIMEOUT, 64, max cycles waited for a sub-unit ready (1..255)

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous active-low reset
- req0, req1  in  1  request; held high with operands stable until own done
- a0, b0, n0  in  DATA_WIDTH  requester 0 operands and modulus
- a1, b1, n1  in  DATA_WIDTH  requester 1 operands and modulus
- done0, done1  out  1  one-cycle completion pulse to the granted requester
- result  out  DATA_WIDTH  registered `(a*b) mod n`; valid while done0/done1 is high
- err  out  1  high with done when n==0 or on timeout; result is then 0
- grant  out  2  one-hot current owner; 00 when idle
- emul_a, emul_b  out  DATA_WIDTH  multiplier operands
- emul_en, emul_rst  out  1  multiplier enable and active-high clear pulse
- emul_x  in  DATA_DOUBLE_WIDTH  product
- emul_ready  in  1  product valid
- modn_a  out  DATA_DOUBLE_WIDTH  dividend, registered from emul_x
- modn_b  out  DATA_WIDTH  modulus
- modn_en, modn_rst  out  1  reducer enable and clear pulse
- modn_x  in  DATA_WIDTH  remainder
- modn_ready  in  1  remainder valid

## Operation
- States: IDLE, MCLR, MUL, RCLR, RED, DONE.
- Reset values: all outputs 0, state IDLE, last-served pointer = 1. With this pointer, requester 0 wins the first tie.
- IDLE, arbitration:
  - If exactly one req is high, grant it.
  - If both are high, grant the one not last served, then update the pointer.
  - Latch the granted a/b/n into emul_a/emul_b/modn_b.
- Zero modulus: if the latched n==0, go directly to DONE with err=1 and result=0. The sub-units are not touched.
- Normal path from IDLE goes to MCLR.
- MCLR: emul_rst=1 for exactly one cycle, then MUL.
- MUL:
  - emul_en=1 until emul_ready is sampled high.
  - On emul_ready, register modn_a<=emul_x, drop emul_en, go to RCLR.
- RCLR: modn_rst=1 for one cycle, then RED.
- RED: modn_en=1 until modn_ready; on modn_ready, register result<=modn_x and go to DONE.
- DONE:
  - Pulse done for the granted requester for one cycle. err reflects the abort cause.
  - Next state is IDLE and grant returns to 00.
  - result holds its value until the next DONE.
- Timeout:
  - An 8-bit wait counter clears on entry to MUL and to RED and increments each cycle while waiting.
  - On reaching TIMEOUT without ready: drop the enables, go to DONE with err=1 and result=0.
- Timeout takes precedence only when ready is low; ready arriving on the TIMEOUT cycle is a success.
- A req that drops while granted is ignored; the operation completes and done still pulses.
- Reset asserted mid-operation: immediate return to reset values; no done is issued, and the requester must re-request.

## Timing
- Requests are sampled only in IDLE. Sampling is edge-free: req still high in the cycle after done starts a new operation. Requesters must drop req on the cycle after done if no new operation is wanted.
- Latency from req high in IDLE to done:
  - Normal: 5 + Tm + Tr cycles, where Tm and Tr are the cycles from enable to ready (≥1) for the multiplier and reducer.
  - n==0: done 2 cycles after req.
- Back-to-back operations: minimum 1 IDLE cycle between a done and the next grant.
- Enables are held continuously until ready; they are never re-pulsed within one operation.

## Test plan
- Single operation: req0, a0=7, b0=9, n0=11, with 3-cycle sub-unit models -> done0 after 11 cycles, result=8, err=0, done1 never pulses.
- Large operands: req1, a1=200, b1=250, n1=251 -> modn_a=50000, result=51, grant=10 throughout.
- Tie and fairness: req0 and req1 both held high from the first cycle after reset -> services alternate 0,1,0,1 (first done0), with no starvation over 8 operations.
- Zero modulus: n0=0 -> done0 2 cycles after req, err=1, result=0, and emul_en/modn_en never assert.
- Timeout: emul_ready tied low, TIMEOUT=64 -> emul_en high for exactly 64 cycles, then done with err=1; the next request with a healthy model succeeds.
- Reset mid-operation: reset low during MUL -> all outputs 0 immediately and no done; after release, the pending req0 is re-granted and completes correctly.

Source files
------------

// File: rtl/modmul_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module  : modmul_arbiter_if
//  Purpose : Bundle of requester and sub-unit signals around the shared
//            modular-multiply arbiter.
//  Modports:
//    slave  - arbiter view: takes req/operands and sub-unit results, drives
//             done/result/err/grant and the sub-unit controls.
//    master - environment view (requesters plus multiplier/reducer).
//  Signals : req0/req1, a0/b0/n0, a1/b1/n1, done0/done1, result, err, grant,
//            emul_a/emul_b/emul_en/emul_rst/emul_x/emul_ready,
//            modn_a/modn_b/modn_en/modn_rst/modn_x/modn_ready
//  Revision: 1.0 - initial release
// ============================================================================
interface modmul_arbiter_if #(
  parameter int DATA_WIDTH        = 8,
  parameter int DATA_DOUBLE_WIDTH = 16
);
  logic                         req0;
  logic                         req1;
  logic [DATA_WIDTH-1:0]        a0;
  logic [DATA_WIDTH-1:0]        b0;
  logic [DATA_WIDTH-1:0]        n0;
  logic [DATA_WIDTH-1:0]        a1;
  logic [DATA_WIDTH-1:0]        b1;
  logic [DATA_WIDTH-1:0]        n1;
  logic                         done0;
  logic                         done1;
  logic [DATA_WIDTH-1:0]        result;
  logic                         err;
  logic [1:0]                   grant;
  logic [DATA_WIDTH-1:0]        emul_a;
  logic [DATA_WIDTH-1:0]        emul_b;
  logic                         emul_en;
  logic                         emul_rst;
  logic [DATA_DOUBLE_WIDTH-1:0] emul_x;
  logic                         emul_ready;
  logic [DATA_DOUBLE_WIDTH-1:0] modn_a;
  logic [DATA_WIDTH-1:0]        modn_b;
  logic                         modn_en;
  logic                         modn_rst;
  logic [DATA_WIDTH-1:0]        modn_x;
  logic                         modn_ready;

  modport slave (
    input  req0, req1, a0, b0, n0, a1, b1, n1,
    input  emul_x, emul_ready, modn_x, modn_ready,
    output done0, done1, result, err, grant,
    output emul_a, emul_b, emul_en, emul_rst,
    output modn_a, modn_b, modn_en, modn_rst
  );

  modport master (
    output req0, req1, a0, b0, n0, a1, b1, n1,
    output emul_x, emul_ready, modn_x, modn_ready,
    input  done0, done1, result, err, grant,
    input  emul_a, emul_b, emul_en, emul_rst,
    input  modn_a, modn_b, modn_en, modn_rst
  );
endinterface
`default_nettype wire

// File: rtl/modmul_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : modmul_arbiter
//  Purpose : Round-robin arbiter and sequencer that lets two requesters share
//            one multiplier (emul_sql) and one reducer (modn) to compute
//            (a*b) mod n. Flags zero moduli and sub-unit timeouts.
//  Ports   :
//    clock - rising-edge clock
//    reset - asynchronous active-low reset
//    bus   - modmul_arbiter_if.slave (requests, operands, results, sub-unit
//            control and status)
//  Revision: 1.0 - initial release
// ============================================================================
module modmul_arbiter #(
  parameter int DATA_WIDTH        = 8,
  parameter int DATA_DOUBLE_WIDTH = 16,
  parameter int TIMEOUT           = 64
) (
  input  wire logic         clock,
  input  wire logic         reset,
  modmul_arbiter_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MCLR = 3'd1,
    S_MUL  = 3'd2,
    S_RCLR = 3'd3,
    S_RED  = 3'd4,
    S_DONE = 3'd5
  } state_t;

  // Wait counter value at which the final permitted ready sample occurs.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t                       state_q;
  logic                         last_q;     // last requester served
  logic [7:0]                   wait_q;
  logic [1:0]                   grant_q;
  logic                         done0_q;
  logic                         done1_q;
  logic                         err_q;
  logic [DATA_WIDTH-1:0]        result_q;
  logic [DATA_WIDTH-1:0]        emul_a_q;
  logic [DATA_WIDTH-1:0]        emul_b_q;
  logic                         emul_en_q;
  logic                         emul_rst_q;
  logic [DATA_DOUBLE_WIDTH-1:0] modn_a_q;
  logic [DATA_WIDTH-1:0]        modn_b_q;
  logic                         modn_en_q;
  logic                         modn_rst_q;

  logic [1:0]                   arb_d;
  logic [DATA_WIDTH-1:0]        sel_n_d;

  // On a tie the requester that was not served last wins.
  always_comb begin
    arb_d = 2'b00;
    if (bus.req0 && bus.req1) begin
      arb_d = last_q ? 2'b01 : 2'b10;
    end else if (bus.req0) begin
      arb_d = 2'b01;
    end else if (bus.req1) begin
      arb_d = 2'b10;
    end
    sel_n_d = arb_d[1] ? bus.n1 : bus.n0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      last_q     <= 1'b1;
      wait_q     <= '0;
      grant_q    <= 2'b00;
      done0_q    <= 1'b0;
      done1_q    <= 1'b0;
      err_q      <= 1'b0;
      result_q   <= '0;
      emul_a_q   <= '0;
      emul_b_q   <= '0;
      emul_en_q  <= 1'b0;
      emul_rst_q <= 1'b0;
      modn_a_q   <= '0;
      modn_b_q   <= '0;
      modn_en_q  <= 1'b0;
      modn_rst_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (grant_q != 2'b00) begin
            // A grant is only held in IDLE when the latched modulus was zero:
            // abort without touching the sub-units.
            state_q  <= S_DONE;
            done0_q  <= grant_q[0];
            done1_q  <= grant_q[1];
            err_q    <= 1'b1;
            result_q <= '0;
          end else if (arb_d != 2'b00) begin
            grant_q  <= arb_d;
            last_q   <= arb_d[1];
            emul_a_q <= arb_d[1] ? bus.a1 : bus.a0;
            emul_b_q <= arb_d[1] ? bus.b1 : bus.b0;
            modn_b_q <= sel_n_d;
            if (sel_n_d != '0) begin
              state_q    <= S_MCLR;
              emul_rst_q <= 1'b1;
            end
          end
        end

        S_MCLR: begin
          emul_rst_q <= 1'b0;
          emul_en_q  <= 1'b1;
          wait_q     <= '0;
          state_q    <= S_MUL;
        end

        S_MUL: begin
          // Ready wins over timeout when both land on the same cycle.
          if (bus.emul_ready) begin
            emul_en_q  <= 1'b0;
            modn_a_q   <= bus.emul_x;
            modn_rst_q <= 1'b1;
            state_q    <= S_RCLR;
          end else if (wait_q == TMO_LAST) begin
            emul_en_q <= 1'b0;
            state_q   <= S_DONE;
            done0_q   <= grant_q[0];
            done1_q   <= grant_q[1];
            err_q     <= 1'b1;
            result_q  <= '0;
          end else begin
            wait_q <= wait_q + 8'd1;
          end
        end

        S_RCLR: begin
          modn_rst_q <= 1'b0;
          modn_en_q  <= 1'b1;
          wait_q     <= '0;
          state_q    <= S_RED;
        end

        S_RED: begin
          if (bus.modn_ready) begin
            modn_en_q <= 1'b0;
            result_q  <= bus.modn_x;
            err_q     <= 1'b0;
            done0_q   <= grant_q[0];
            done1_q   <= grant_q[1];
            state_q   <= S_DONE;
          end else if (wait_q == TMO_LAST) begin
            modn_en_q <= 1'b0;
            state_q   <= S_DONE;
            done0_q   <= grant_q[0];
            done1_q   <= grant_q[1];
            err_q     <= 1'b1;
            result_q  <= '0;
          end else begin
            wait_q <= wait_q + 8'd1;
          end
        end

        S_DONE: begin
          done0_q <= 1'b0;
          done1_q <= 1'b0;
          err_q   <= 1'b0;
          grant_q <= 2'b00;
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.done0    = done0_q;
  assign bus.done1    = done1_q;
  assign bus.result   = result_q;
  assign bus.err      = err_q;
  assign bus.grant    = grant_q;
  assign bus.emul_a   = emul_a_q;
  assign bus.emul_b   = emul_b_q;
  assign bus.emul_en  = emul_en_q;
  assign bus.emul_rst = emul_rst_q;
  assign bus.modn_a   = modn_a_q;
  assign bus.modn_b   = modn_b_q;
  assign bus.modn_en  = modn_en_q;
  assign bus.modn_rst = modn_rst_q;

endmodule
`default_nettype wire

// File: tb/tb_modmul_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : tb_modmul_arbiter
//  Purpose : Directed self-checking bench for modmul_arbiter with simple
//            fixed-latency multiplier and reducer models.
//  Revision: 1.0 - initial release
// ============================================================================
module tb_modmul_arbiter;

  localparam int DW = 8;
  localparam int DDW = 16;
  localparam int TMO = 64;
  localparam logic [7:0] TM = 8'd3;
  localparam logic [7:0] TR = 8'd3;

  logic clock;
  logic reset;
  logic mul_ok;
  logic [7:0] mcnt;
  logic [7:0] rcnt;
  int n_cmp;
  int n_bad;

  modmul_arbiter_if #(.DATA_WIDTH(DW), .DATA_DOUBLE_WIDTH(DDW)) bus ();

  modmul_arbiter #(
    .DATA_WIDTH(DW),
    .DATA_DOUBLE_WIDTH(DDW),
    .TIMEOUT(TMO)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Multiplier model: ready once enable has been seen on TM rising edges.
  always @(posedge clock or negedge reset) begin
    if (!reset) mcnt <= 8'd0;
    else if (bus.emul_rst) mcnt <= 8'd0;
    else if (bus.emul_en && mcnt < TM) mcnt <= mcnt + 8'd1;
  end
  assign bus.emul_ready = mul_ok && (mcnt == TM);
  assign bus.emul_x = 16'(bus.emul_a) * 16'(bus.emul_b);

  // Reducer model, same latency scheme.
  always @(posedge clock or negedge reset) begin
    if (!reset) rcnt <= 8'd0;
    else if (bus.modn_rst) rcnt <= 8'd0;
    else if (bus.modn_en && rcnt < TR) rcnt <= rcnt + 8'd1;
  end
  assign bus.modn_ready = (rcnt == TR);
  assign bus.modn_x = (bus.modn_b == 8'd0) ? 8'd0 : 8'(bus.modn_a % 16'(bus.modn_b));

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic settle();
    @(negedge clock);
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.a0 = '0; bus.b0 = '0; bus.n0 = '0;
    bus.a1 = '0; bus.b1 = '0; bus.n1 = '0;
    @(negedge clock);
    @(negedge clock);
    n_cmp++;
    if (bus.grant !== 2'b00) begin
      n_bad++; $display("FAIL reset_grant: got %b expected 00", bus.grant);
    end
    n_cmp++;
    if ({bus.done0, bus.done1, bus.err} !== 3'b000) begin
      n_bad++; $display("FAIL reset_done_err: got %b expected 000", {bus.done0, bus.done1, bus.err});
    end
    n_cmp++;
    if ({bus.emul_en, bus.emul_rst, bus.modn_en, bus.modn_rst} !== 4'b0000) begin
      n_bad++; $display("FAIL reset_ctrl: got %b expected 0000",
                        {bus.emul_en, bus.emul_rst, bus.modn_en, bus.modn_rst});
    end
    n_cmp++;
    if (bus.result !== 8'd0) begin
      n_bad++; $display("FAIL reset_result: got %0d expected 0", bus.result);
    end
    reset = 1'b1;
    settle();
  endtask

  task automatic test_single();
    int got;
    bit seen1;
    got = -1; seen1 = 1'b0;
    bus.a0 = 8'd7; bus.b0 = 8'd9; bus.n0 = 8'd11; bus.req0 = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clock);
      if (bus.done1) seen1 = 1'b1;
      if (bus.done0) begin got = c; break; end
    end
    bus.req0 = 1'b0;
    n_cmp++;
    if (got !== 11) begin n_bad++; $display("FAIL single_latency: got %0d expected 11", got); end
    n_cmp++;
    if (bus.result !== 8'd8) begin n_bad++; $display("FAIL single_result: got %0d expected 8", bus.result); end
    n_cmp++;
    if (bus.err !== 1'b0) begin n_bad++; $display("FAIL single_err: got %b expected 0", bus.err); end
    n_cmp++;
    if (seen1 !== 1'b0) begin n_bad++; $display("FAIL single_done1: got %b expected 0", seen1); end
    settle();
  endtask

  task automatic test_large();
    int got;
    bit bad_grant;
    got = -1; bad_grant = 1'b0;
    bus.a1 = 8'd200; bus.b1 = 8'd250; bus.n1 = 8'd251; bus.req1 = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clock);
      if (bus.grant !== 2'b10) bad_grant = 1'b1;
      if (bus.done1) begin got = c; break; end
    end
    bus.req1 = 1'b0;
    n_cmp++;
    if (got !== 11) begin n_bad++; $display("FAIL large_latency: got %0d expected 11", got); end
    n_cmp++;
    if (bus.modn_a !== 16'd50000) begin n_bad++; $display("FAIL large_modn_a: got %0d expected 50000", bus.modn_a); end
    n_cmp++;
    if (bus.result !== 8'd51) begin n_bad++; $display("FAIL large_result: got %0d expected 51", bus.result); end
    n_cmp++;
    if (bad_grant !== 1'b0) begin n_bad++; $display("FAIL large_grant: got off-10 grant %b expected 0", bad_grant); end
    settle();
  endtask

  task automatic test_tie();
    int owner;
    reset = 1'b0;
    bus.a0 = 8'd7; bus.b0 = 8'd9; bus.n0 = 8'd11;
    bus.a1 = 8'd200; bus.b1 = 8'd250; bus.n1 = 8'd251;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    @(negedge clock);
    reset = 1'b1;
    for (int op = 0; op < 8; op++) begin
      owner = -1;
      for (int c = 1; c <= 30; c++) begin
        @(negedge clock);
        if (bus.done0) begin owner = 0; break; end
        if (bus.done1) begin owner = 1; break; end
      end
      n_cmp++;
      if (owner !== (op % 2)) begin
        n_bad++; $display("FAIL tie_owner op%0d: got %0d expected %0d", op, owner, op % 2);
      end
      n_cmp++;
      if (bus.result !== ((op % 2 == 0) ? 8'd8 : 8'd51)) begin
        n_bad++; $display("FAIL tie_result op%0d: got %0d expected %0d", op, bus.result,
                          (op % 2 == 0) ? 8 : 51);
      end
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    settle();
  endtask

  task automatic test_zero_mod();
    int got;
    bit en_seen;
    got = -1; en_seen = 1'b0;
    bus.a0 = 8'd5; bus.b0 = 8'd6; bus.n0 = 8'd0; bus.req0 = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clock);
      if (bus.emul_en || bus.modn_en) en_seen = 1'b1;
      if (bus.done0) begin got = c; break; end
    end
    bus.req0 = 1'b0;
    n_cmp++;
    if (got !== 2) begin n_bad++; $display("FAIL zero_latency: got %0d expected 2", got); end
    n_cmp++;
    if (bus.err !== 1'b1) begin n_bad++; $display("FAIL zero_err: got %b expected 1", bus.err); end
    n_cmp++;
    if (bus.result !== 8'd0) begin n_bad++; $display("FAIL zero_result: got %0d expected 0", bus.result); end
    n_cmp++;
    if (en_seen !== 1'b0) begin n_bad++; $display("FAIL zero_enables: got %b expected 0", en_seen); end
    settle();
  endtask

  task automatic test_timeout();
    int en_cnt;
    int got;
    en_cnt = 0; got = -1;
    mul_ok = 1'b0;
    bus.a0 = 8'd7; bus.b0 = 8'd9; bus.n0 = 8'd11; bus.req0 = 1'b1;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clock);
      if (bus.emul_en) en_cnt++;
      if (bus.done0) begin got = c; break; end
    end
    bus.req0 = 1'b0;
    n_cmp++;
    if (en_cnt !== 64) begin n_bad++; $display("FAIL timeout_en_cycles: got %0d expected 64", en_cnt); end
    n_cmp++;
    if (got === -1 || bus.err !== 1'b1) begin
      n_bad++; $display("FAIL timeout_err: got done@%0d err=%b expected err=1", got, bus.err);
    end
    n_cmp++;
    if (bus.result !== 8'd0) begin n_bad++; $display("FAIL timeout_result: got %0d expected 0", bus.result); end
    settle();
    mul_ok = 1'b1;
    got = -1;
    bus.req0 = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clock);
      if (bus.done0) begin got = c; break; end
    end
    bus.req0 = 1'b0;
    n_cmp++;
    if (got !== 11 || bus.err !== 1'b0 || bus.result !== 8'd8) begin
      n_bad++; $display("FAIL timeout_recover: got done@%0d err=%b result=%0d expected 11/0/8",
                        got, bus.err, bus.result);
    end
    settle();
  endtask

  task automatic test_reset_mid();
    int got;
    bit en_hit;
    bit done_seen;
    got = -1; en_hit = 1'b0; done_seen = 1'b0;
    bus.a0 = 8'd7; bus.b0 = 8'd9; bus.n0 = 8'd11; bus.req0 = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clock);
      if (bus.emul_en) begin en_hit = 1'b1; break; end
    end
    n_cmp++;
    if (en_hit !== 1'b1) begin n_bad++; $display("FAIL rstmid_reach_mul: got %b expected 1", en_hit); end
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({bus.grant, bus.emul_en, bus.emul_rst, bus.modn_en, bus.modn_rst, bus.done0, bus.done1, bus.err} !== 9'd0
        || bus.result !== 8'd0) begin
      n_bad++; $display("FAIL rstmid_outputs: got grant=%b en=%b result=%0d expected all 0",
                        bus.grant, bus.emul_en, bus.result);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      if (bus.done0 || bus.done1) done_seen = 1'b1;
    end
    n_cmp++;
    if (done_seen !== 1'b0) begin n_bad++; $display("FAIL rstmid_no_done: got %b expected 0", done_seen); end
    reset = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clock);
      if (bus.done0) begin got = c; break; end
    end
    bus.req0 = 1'b0;
    n_cmp++;
    if (got !== 11 || bus.result !== 8'd8) begin
      n_bad++; $display("FAIL rstmid_regrant: got done@%0d result=%0d expected 11/8", got, bus.result);
    end
    settle();
  endtask

  task automatic test_back_to_back();
    int got;
    got = -1;
    bus.a0 = 8'd7; bus.b0 = 8'd9; bus.n0 = 8'd11; bus.req0 = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clock);
      if (bus.done0) begin got = c; break; end
    end
    n_cmp++;
    if (got !== 11) begin n_bad++; $display("FAIL b2b_first: got %0d expected 11", got); end
    @(negedge clock);
    n_cmp++;
    if (bus.grant !== 2'b00) begin n_bad++; $display("FAIL b2b_idle_gap: got %b expected 00", bus.grant); end
    @(negedge clock);
    n_cmp++;
    if (bus.grant !== 2'b01) begin n_bad++; $display("FAIL b2b_regrant: got %b expected 01", bus.grant); end
    got = -1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clock);
      if (bus.done0) begin got = c; break; end
    end
    bus.req0 = 1'b0;
    n_cmp++;
    if (got !== 10 || bus.result !== 8'd8) begin
      n_bad++; $display("FAIL b2b_second: got done@%0d result=%0d expected 10/8", got, bus.result);
    end
    settle();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    mul_ok = 1'b1;
    reset = 1'b0;
    test_reset();
    test_single();
    test_large();
    test_zero_mod();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_tie();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
